// File: rtl/vga_color_mixer_pipe_if.sv
// Pixel, palette-write and fade-control bundle for vga_color_mixer_pipe.
// master = pixel source / controller, slave = the colour mixer itself.
`timescale 1ns/1ps
interface vga_color_mixer_pipe_if #(
    parameter int SEL_W = 4,
    parameter int PIX_W = 16
);
    logic             pix_valid_in;
    logic [SEL_W-1:0] color_sel;
    logic [1:0]       dith_phase;
    logic             pal_we;
    logic [SEL_W-1:0] pal_addr;
    logic [23:0]      pal_wdata;
    logic             fade_start;
    logic [7:0]       fade_target;
    logic             fade_busy;
    logic [7:0]       white_ratio;
    logic             pix_valid_out;
    logic [PIX_W-1:0] vga_data;

    modport master (
        output pix_valid_in, color_sel, dith_phase,
        output pal_we, pal_addr, pal_wdata,
        output fade_start, fade_target,
        input  fade_busy, white_ratio, pix_valid_out, vga_data
    );

    modport slave (
        input  pix_valid_in, color_sel, dith_phase,
        input  pal_we, pal_addr, pal_wdata,
        input  fade_start, fade_target,
        output fade_busy, white_ratio, pix_valid_out, vga_data
    );
endinterface

// File: rtl/vga_color_mixer_pipe.sv
// Palette-to-RGB colour stage: palette lookup, blend toward white by the
// current white ratio, truncate and pack to {R,G,B}. Fixed 3-clock latency,
// one pixel per clock. A fade engine ramps white_ratio toward a target.
// Optional feature: define DITHER_EN to add a 2x2 Bayer threshold (selected
// by dith_phase) before truncation; without it dith_phase is ignored.
`timescale 1ns/1ps
module vga_color_mixer_pipe #(
    parameter int NUM_COLORS = 16,
    parameter int SEL_W      = 4,
    parameter int R_OUT      = 5,
    parameter int G_OUT      = 6,
    parameter int B_OUT      = 5,
    parameter int FADE_DIV   = 1024,
    parameter int FADE_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_color_mixer_pipe_if.slave  bus
);
    localparam int PIX_W = R_OUT + G_OUT + B_OUT;
    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(FADE_DIV - 1);
    localparam logic [SEL_W:0]   NUM_C   = (SEL_W + 1)'(NUM_COLORS);
    localparam logic [7:0]       STEP    = 8'(FADE_STEP);

    typedef enum logic {IDLE, RAMP} fade_state_t;

    // Power-on palette contents.
    function automatic logic [23:0] reset_color(input int idx);
        case (idx)
            1:       return 24'hFFFFFF;
            2:       return 24'hFF0000;
            3:       return 24'h00FF00;
            4:       return 24'h0000FF;
            5:       return 24'hFFFF00;
            6:       return 24'h00FFFF;
            7:       return 24'hFF00FF;
            8:       return 24'h808080;
            default: return 24'h000000;
        endcase
    endfunction

    // Blend one channel toward white: (c*(255-w) + 255*w) >> 8, never above 254.
    function automatic logic [7:0] blend(input logic [7:0] c, input logic [7:0] w);
        logic [16:0] acc;
        acc = 17'(c) * 17'(8'd255 - w) + 17'(255) * 17'(w);
        return 8'(acc >> 8);
    endfunction

    // One fade step toward the target, clamped so it never overshoots.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) <= STEP) ? tgt : cur + STEP;
        else
            return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
    endfunction

    // Truncate each channel to its top bits and pack {R,G,B}, MSB first.
    function automatic logic [PIX_W-1:0] pack(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
        return (PIX_W'(r >> (8 - R_OUT)) << (G_OUT + B_OUT))
             | (PIX_W'(g >> (8 - G_OUT)) << B_OUT)
             |  PIX_W'(b >> (8 - B_OUT));
    endfunction

`ifdef DITHER_EN
    // Add the Bayer threshold scaled to the k dropped bits, saturating at 255.
    function automatic logic [7:0] dither_add(input logic [7:0] v, input logic [1:0] ph,
                                              input int k);
        logic [1:0] t;
        logic [7:0] thr;
        logic [8:0] sum;
        case (ph)
            2'b00:   t = 2'd0;
            2'b01:   t = 2'd2;
            2'b10:   t = 2'd3;
            default: t = 2'd1;
        endcase
        if (k >= 2) thr = 8'(t) << (k - 2);
        else        thr = 8'(t) >> (2 - k);
        sum = {1'b0, v} + {1'b0, thr};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction
`endif

    logic [23:0]      palette [NUM_COLORS];
    fade_state_t      state;
    logic [7:0]       white_ratio;
    logic [7:0]       target;
    logic             fade_busy;
    logic [PRE_W-1:0] presc;
    logic [7:0]       tgt_eff;
    logic [7:0]       ratio_step;
    logic             wrap;

    logic             sel_ok;
    logic             vld_p1, vld_p2;
    logic [23:0]      col_p1;
    logic [7:0]       w_p1;
    logic [7:0]       r_p2, g_p2, b_p2;
    logic [7:0]       r_adj, g_adj, b_adj;
    logic             pix_valid_out;
    logic [PIX_W-1:0] vga_data;

`ifdef DITHER_EN
    logic [1:0]       ph_p1, ph_p2;
`else
    logic             unused_phase;
    assign unused_phase = ^bus.dith_phase;
`endif

    // Palette storage: reset to the default colours, writes land at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COLORS; i++) palette[i] <= reset_color(i);
        end else if (bus.pal_we && ({1'b0, bus.pal_addr} < NUM_C)) begin
            palette[bus.pal_addr] <= bus.pal_wdata;
        end
    end

    // Effective target (a same-cycle retarget wins) and the clamped next ratio.
    always_comb begin
        tgt_eff    = bus.fade_start ? bus.fade_target : target;
        ratio_step = step_toward(white_ratio, tgt_eff);
        wrap       = (presc == PRE_MAX);
    end

    // Fade engine: IDLE waits for a start, RAMP steps the ratio at each prescaler wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            white_ratio <= 8'd0;
            target      <= 8'd0;
            fade_busy   <= 1'b0;
            presc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fade_start) begin
                        target <= bus.fade_target;
                        presc  <= '0;
                        if (bus.fade_target != white_ratio) begin
                            state     <= RAMP;
                            fade_busy <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    target <= tgt_eff;
                    presc  <= wrap ? '0 : presc + 1'b1;
                    if (bus.fade_start && (bus.fade_target == white_ratio)) begin
                        state     <= IDLE;
                        fade_busy <= 1'b0;
                    end else if (wrap) begin
                        white_ratio <= ratio_step;
                        if (ratio_step == tgt_eff) begin
                            state     <= IDLE;
                            fade_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign sel_ok = ({1'b0, bus.color_sel} < NUM_C);

    // Datapath registers (no reset; qualified by the valid pipeline).
    always_ff @(posedge clk) begin
        // ---- S1: palette entry, ratio sample ----
        col_p1 <= sel_ok ? palette[bus.color_sel] : 24'h000000;
        w_p1   <= white_ratio;
        // ---- S2: blend toward white ----
        r_p2   <= blend(col_p1[23:16], w_p1);
        g_p2   <= blend(col_p1[15:8],  w_p1);
        b_p2   <= blend(col_p1[7:0],   w_p1);
`ifdef DITHER_EN
        ph_p1  <= bus.dith_phase;
        ph_p2  <= ph_p1;
`endif
    end

    // S3 channel conditioning ahead of truncation.
    always_comb begin
`ifdef DITHER_EN
        r_adj = dither_add(r_p2, ph_p2, 8 - R_OUT);
        g_adj = dither_add(g_p2, ph_p2, 8 - G_OUT);
        b_adj = dither_add(b_p2, ph_p2, 8 - B_OUT);
`else
        r_adj = r_p2;
        g_adj = g_p2;
        b_adj = b_p2;
`endif
    end

    // Valid pipeline and packed output register; reset flushes in-flight pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            pix_valid_out <= 1'b0;
            vga_data      <= '0;
        end else begin
            vld_p1        <= bus.pix_valid_in;
            vld_p2        <= vld_p1;
            // ---- S3: truncate, pack, register ----
            pix_valid_out <= vld_p2;
            if (vld_p2) vga_data <= pack(r_adj, g_adj, b_adj);
        end
    end

    assign bus.fade_busy     = fade_busy;
    assign bus.white_ratio   = white_ratio;
    assign bus.pix_valid_out = pix_valid_out;
    assign bus.vga_data      = vga_data;
endmodule

// File: tb/tb_vga_color_mixer_pipe.sv
// Directed bench for vga_color_mixer_pipe: a 12-colour, fast-fade instance
// for the pixel path, plus a large-step instance for the fade clamp/retarget.
`timescale 1ns/1ps
module tb_vga_color_mixer_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_color_mixer_pipe_if #(.SEL_W(4), .PIX_W(16)) bus_a ();
    vga_color_mixer_pipe_if #(.SEL_W(4), .PIX_W(16)) bus_b ();

    vga_color_mixer_pipe #(.NUM_COLORS(12), .SEL_W(4), .R_OUT(5), .G_OUT(6), .B_OUT(5),
                           .FADE_DIV(4), .FADE_STEP(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    vga_color_mixer_pipe #(.NUM_COLORS(16), .SEL_W(4), .R_OUT(5), .G_OUT(6), .B_OUT(5),
                           .FADE_DIV(2), .FADE_STEP(100))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic [15:0] exp;
    } vec_t;

    vec_t tab_w0 [12];
    vec_t tab_w128 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single pixel through A; checks exact 3-clock latency and the packed value.
    task automatic pixel_check(input string name, input logic [3:0] sel, input logic [1:0] ph,
                               input logic [15:0] exp);
        bus_a.pix_valid_in = 1'b1;
        bus_a.color_sel    = sel;
        bus_a.dith_phase   = ph;
        tick(1);
        bus_a.pix_valid_in = 1'b0;
        tick(1);
        check({name, "_early"}, 32'(bus_a.pix_valid_out), 32'd0);
        tick(1);
        check({name, "_vld"}, 32'(bus_a.pix_valid_out), 32'd1);
        check(name, 32'(bus_a.vga_data), 32'(exp));
    endtask

    task automatic fade_b(input logic [7:0] tgt);
        bus_b.fade_start  = 1'b1;
        bus_b.fade_target = tgt;
        tick(1);
        bus_b.fade_start  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       bv [6];
        logic [3:0] bs [6];
        logic [15:0] be [6];

        tab_w0[0]  = '{"w0_blk",   4'd0,  16'h0000};
        tab_w0[1]  = '{"w0_wht",   4'd1,  16'hFFFF};
        tab_w0[2]  = '{"w0_red",   4'd2,  16'hF800};
        tab_w0[3]  = '{"w0_grn",   4'd3,  16'h07E0};
        tab_w0[4]  = '{"w0_blu",   4'd4,  16'h001F};
        tab_w0[5]  = '{"w0_yel",   4'd5,  16'hFFE0};
        tab_w0[6]  = '{"w0_cyn",   4'd6,  16'h07FF};
        tab_w0[7]  = '{"w0_mag",   4'd7,  16'hF81F};
        tab_w0[8]  = '{"w0_gry",   4'd8,  16'h7BEF};
        tab_w0[9]  = '{"w0_e9",    4'd9,  16'h0000};
        tab_w0[10] = '{"w0_e11",   4'd11, 16'h0000};
        tab_w0[11] = '{"w0_oor15", 4'd15, 16'h0000};

        tab_w128[0] = '{"w128_red", 4'd2, 16'hFBEF};
        tab_w128[1] = '{"w128_wht", 4'd1, 16'hFFFF};
        tab_w128[2] = '{"w128_blk", 4'd0, 16'h7BEF};
        tab_w128[3] = '{"w128_blu", 4'd4, 16'h7BFF};
        tab_w128[4] = '{"w128_gry", 4'd8, 16'hBDF7};

        bv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bs = '{4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd0};
        be = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'hFFE0, 16'h0000};

        rst = 1'b1;
        bus_a.pix_valid_in = 1'b0; bus_a.color_sel = '0; bus_a.dith_phase = '0;
        bus_a.pal_we = 1'b0; bus_a.pal_addr = '0; bus_a.pal_wdata = '0;
        bus_a.fade_start = 1'b0; bus_a.fade_target = '0;
        bus_b.pix_valid_in = 1'b0; bus_b.color_sel = '0; bus_b.dith_phase = '0;
        bus_b.pal_we = 1'b0; bus_b.pal_addr = '0; bus_b.pal_wdata = '0;
        bus_b.fade_start = 1'b0; bus_b.fade_target = '0;
        tick(2);
        check("rst_valid", 32'(bus_a.pix_valid_out), 32'd0);
        check("rst_data",  32'(bus_a.vga_data),      32'd0);
        check("rst_busy",  32'(bus_a.fade_busy),     32'd0);
        check("rst_ratio", 32'(bus_a.white_ratio),   32'd0);
        rst = 1'b0;
        tick(1);

        // Palette at ratio 0.
        for (int i = 0; i < 12; i++) pixel_check(tab_w0[i].name, tab_w0[i].sel, 2'b00, tab_w0[i].exp);

        // Palette write then read back.
        bus_a.pal_we = 1'b1; bus_a.pal_addr = 4'd9; bus_a.pal_wdata = 24'h00FF00;
        tick(1);
        bus_a.pal_we = 1'b0;
        pixel_check("wr9", 4'd9, 2'b00, 16'h07E0);

        // Same-cycle write and read of entry 10: the read sees the old value.
        bus_a.pal_we = 1'b1; bus_a.pal_addr = 4'd10; bus_a.pal_wdata = 24'hFF0000;
        pixel_check("rw10_old", 4'd10, 2'b00, 16'h0000);
        bus_a.pal_we = 1'b0;
        pixel_check("rw10_new", 4'd10, 2'b00, 16'hF800);

        // Back-to-back pixels with a bubble.
        for (int c = 0; c < 8; c++) begin
            bus_a.pix_valid_in = (c < 6) ? bv[c] : 1'b0;
            bus_a.color_sel    = (c < 6) ? bs[c] : 4'd0;
            tick(1);
            if (c >= 2) begin
                check($sformatf("burst_vld%0d", c - 2), 32'(bus_a.pix_valid_out), 32'(bv[c - 2]));
                if (bv[c - 2]) check($sformatf("burst_dat%0d", c - 2), 32'(bus_a.vga_data), 32'(be[c - 2]));
            end else begin
                check($sformatf("burst_pre%0d", c), 32'(bus_a.pix_valid_out), 32'd0);
            end
        end

        // Fade 0 -> 3, one step every 4 clocks.
        bus_a.fade_start = 1'b1; bus_a.fade_target = 8'd3;
        tick(1);
        bus_a.fade_start = 1'b0;
        check("fade_busy_on", 32'(bus_a.fade_busy), 32'd1);
        for (int s = 1; s <= 3; s++) begin
            tick(3);
            check($sformatf("fade_hold%0d", s), 32'(bus_a.white_ratio), 32'(s - 1));
            tick(1);
            check($sformatf("fade_step%0d", s), 32'(bus_a.white_ratio), 32'(s));
            check($sformatf("fade_busy%0d", s), 32'(bus_a.fade_busy), (s == 3) ? 32'd0 : 32'd1);
        end
        bus_a.fade_start = 1'b1; bus_a.fade_target = 8'd3;
        tick(1);
        bus_a.fade_start = 1'b0;
        check("fade_same_idle", 32'(bus_a.fade_busy), 32'd0);

        // Ramp to 128 and check blended colours.
        bus_a.fade_start = 1'b1; bus_a.fade_target = 8'd128;
        tick(1);
        bus_a.fade_start = 1'b0;
        for (int i = 0; i < 1000 && bus_a.fade_busy; i++) tick(1);
        check("ramp128_busy",  32'(bus_a.fade_busy),   32'd0);
        check("ramp128_ratio", 32'(bus_a.white_ratio), 32'd128);
        for (int i = 0; i < 5; i++) pixel_check(tab_w128[i].name, tab_w128[i].sel, 2'b00, tab_w128[i].exp);

        // Large-step engine: clamp up and down.
        fade_b(8'd150);
        check("b_busy_on", 32'(bus_b.fade_busy), 32'd1);
        tick(1);
        check("b_hold0", 32'(bus_b.white_ratio), 32'd0);
        tick(1);
        check("b_step100", 32'(bus_b.white_ratio), 32'd100);
        tick(2);
        check("b_clamp150", 32'(bus_b.white_ratio), 32'd150);
        check("b_busy_off", 32'(bus_b.fade_busy), 32'd0);
        fade_b(8'd0);
        tick(2);
        check("b_down50", 32'(bus_b.white_ratio), 32'd50);
        tick(2);
        check("b_down0", 32'(bus_b.white_ratio), 32'd0);
        check("b_down_idle", 32'(bus_b.fade_busy), 32'd0);
        // Retarget to the current value mid-ramp stops at once.
        fade_b(8'd200);
        fade_b(8'd0);
        check("b_retgt_same_idle", 32'(bus_b.fade_busy), 32'd0);
        check("b_retgt_same_ratio", 32'(bus_b.white_ratio), 32'd0);
        // Retarget mid-ramp: the prescaler keeps counting.
        fade_b(8'd200);
        fade_b(8'd50);
        check("b_retgt_busy", 32'(bus_b.fade_busy), 32'd1);
        tick(1);
        check("b_retgt_step", 32'(bus_b.white_ratio), 32'd50);
        check("b_retgt_idle", 32'(bus_b.fade_busy), 32'd0);

        // Reset mid-ramp with pixels in flight.
        bus_a.fade_start = 1'b1; bus_a.fade_target = 8'd0;
        tick(1);
        bus_a.fade_start = 1'b0;
        tick(4);
        bus_a.pix_valid_in = 1'b1; bus_a.color_sel = 4'd1;
        tick(3);
        check("pre_rst_vld", 32'(bus_a.pix_valid_out), 32'd1);
        bus_a.pix_valid_in = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_vld",   32'(bus_a.pix_valid_out), 32'd0);
        check("mid_rst_data",  32'(bus_a.vga_data),      32'd0);
        check("mid_rst_busy",  32'(bus_a.fade_busy),     32'd0);
        check("mid_rst_ratio", 32'(bus_a.white_ratio),   32'd0);
        check("mid_rst_b_ratio", 32'(bus_b.white_ratio), 32'd0);
        tick(1);
        check("mid_rst_vld_clk", 32'(bus_a.pix_valid_out), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("post_rst_vld%0d", i), 32'(bus_a.pix_valid_out), 32'd0);
        end
        check("post_rst_busy", 32'(bus_a.fade_busy), 32'd0);
        pixel_check("post_rst_e9",  4'd9,  2'b00, 16'h0000);
        pixel_check("post_rst_e10", 4'd10, 2'b00, 16'h0000);
        pixel_check("post_rst_gry", 4'd8,  2'b00, 16'h7BEF);
`ifdef DITHER_EN
        pixel_check("dith_gry_ph2", 4'd8, 2'b10, 16'h8410);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
